// File: rtl/mips_mem_pkg.sv
// Shared types, defaults and helpers for the unified instruction/data memory port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  localparam int unsigned DEFAULT_MAX_STREAK  = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 255;

  function automatic logic [3:0] streak_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? lim : s + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts BUSY cycles from the grant onward; expired_o rises combinationally in the
// TIMEOUT_CYC-th BUSY cycle so the arbiter can abort at that edge.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic busy_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || start_i) begin
      cnt_q <= '0;
    end else if (busy_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = busy_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and load/store (D), one transaction at a time;
// grant is same-cycle, rvalid one cycle after mem_ack. ARB_TIMEOUT_EN adds a BUSY watchdog abort.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_STREAK  = DEFAULT_MAX_STREAK,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MAX_STREAK == 0 || MAX_STREAK > 15 || TIMEOUT_CYC == 0) begin : g_param_check
    $error("mem_port_arbiter: MAX_STREAK must be 1..15 and TIMEOUT_CYC at least 1");
  end

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  arb_state_t        state_q;
  logic [3:0]        streak_q, streak_d;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_rvalid_q, d_rvalid_q, i_err_q, d_err_q;
  logic              sel_d, sel_i, busy, expired;

  // Data wins unless fetch has already waited through MAX_STREAK data grants.
  assign sel_d = d_req && !(i_req && streak_q == STREAK_MAX);
  assign sel_i = !sel_d && i_req;
  assign d_gnt = (state_q == IDLE) && sel_d && !reset;
  assign i_gnt = (state_q == IDLE) && sel_i && !reset;
  assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);

  always_comb begin
    streak_d = streak_q;
    if (state_q == IDLE) begin
      if (i_gnt || !i_req) begin
        streak_d = '0;
      end else if (d_gnt) begin
        streak_d = streak_inc(streak_q, STREAK_MAX);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .start_i  (i_gnt || d_gnt),
    .busy_i   (busy),
    .expired_o(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_err_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      d_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_gnt) begin
            mem_req_q   <= 1'b1;
            mem_addr_q  <= d_addr;
            mem_we_q    <= d_we;
            mem_wdata_q <= d_wdata;
            state_q     <= BUSY_D;
          end else if (i_gnt) begin
            mem_req_q   <= 1'b1;
            mem_addr_q  <= i_addr;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            state_q     <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          // A real ack takes precedence over a watchdog expiry in the same cycle.
          if (mem_ack || expired) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (state_q == BUSY_I) begin
              i_rvalid_q <= 1'b1;
              i_err_q    <= !mem_ack;
              i_rdata_q  <= mem_ack ? mem_rdata : '0;
            end else begin
              d_rvalid_q <= 1'b1;
              d_err_q    <= !mem_ack;
              d_rdata_q  <= (mem_ack && !mem_we_q) ? mem_rdata : '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign i_err     = i_err_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single transactions, directed corner sequences,
// and random two-requester traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_STREAK(MAXS), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acks in the ack_lat-th cycle of mem_req (0 = never), optional spurious acks.
  bit [31:0] mem_store [bit [31:0]];
  int        ack_lat   = 1;
  bit        spur_en   = 0;
  bit        force_ack = 0;
  int        req_cyc   = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      if (force_ack) begin
        force_ack = 0;
        mem_ack   = 1'b1;
      end else if (mem_req) begin
        req_cyc++;
        if (ack_lat != 0 && req_cyc == ack_lat) begin
          mem_ack = 1'b1;
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_val(mem_addr);
        end
      end else begin
        req_cyc = 0;
        if (spur_en && $urandom_range(0, 5) == 0) mem_ack = 1'b1;
      end
    end
  end

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    ack_lat = v.lat;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_addr = v.addr; d_we = v.we; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    #1;
    chk({t, "_i_gnt"}, i_gnt, !v.is_d);
    chk({t, "_d_gnt"}, d_gnt, v.is_d);
    @(negedge clk);
    // Payload churn after the grant must not reach the memory port.
    i_req = 1'b0; d_req = 1'b0; i_addr = '1; d_addr = '1; d_wdata = '1; d_we = ~v.we;
    #1;
    chk({t, "_mem_we"}, mem_we, v.we);
    if (v.we) chk({t, "_mem_wdata"}, mem_wdata, v.wdata);
    for (int c = 1; c <= v.lat; c++) begin
      if (c > 1) begin @(negedge clk); #1; end
      chk({t, "_mem_req"}, mem_req, 1);
      chk({t, "_mem_addr"}, mem_addr, v.addr);
      chk({t, "_early_rvalid"}, i_rvalid | d_rvalid, 0);
    end
    @(negedge clk); #1;
    chk({t, "_mem_req_drop"}, mem_req, 0);
    chk({t, "_i_rvalid"}, i_rvalid, !v.is_d);
    chk({t, "_d_rvalid"}, d_rvalid, v.is_d);
    chk({t, "_rdata"}, v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    chk({t, "_err"}, i_err | d_err, 0);
    @(negedge clk); #1;
    chk({t, "_rvalid_pulse"}, i_rvalid | d_rvalid, 0);
    chk({t, "_rdata_hold"}, v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    d_we = 1'b0;
  endtask

  // Transaction-level reference state for the random phase.
  bit [31:0]   ref_mem [bit [31:0]];
  int          m_streak = 0;
  bit          m_busy = 0, m_resp = 0, m_owner_d = 0, m_we = 0;
  logic [31:0] m_addr, m_wdata, m_exp;
  logic [31:0] last_i = '0, last_d = '0;
  bit          have_i = 0, have_d = 0;
  bit          prev_ig = 0, prev_dg = 0;
  int          n_grants = 0;

  initial begin
    #300000;
    $display("FAIL sim_time_limit: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    byte   got[10];
    string exp_order;
    int    n;
    bit    e_ig, e_dg, was_free;

    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_i_gnt", i_gnt, 0);       chk("rst_d_gnt", d_gnt, 0);
    chk("rst_i_rvalid", i_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0);   chk("rst_d_rdata", d_rdata, 0);
    chk("rst_i_err", i_err, 0);       chk("rst_d_err", d_err, 0);
    chk("rst_mem_req", mem_req, 0);   chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);     chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    reset = 1'b0;

    mem_store[32'h40]  = 32'h8C01_0004;
    mem_store[32'h104] = 32'h0000_0013;
    mem_store[32'h200] = 32'h1234_5678;
    vecs[0] = '{is_d: 0, we: 0, addr: 32'h40,  wdata: 32'h0,         lat: 2, exp_rdata: 32'h8C01_0004};
    vecs[1] = '{is_d: 1, we: 1, addr: 32'h100, wdata: 32'hDEAD_BEEF, lat: 1, exp_rdata: 32'h0};
    vecs[2] = '{is_d: 1, we: 0, addr: 32'h100, wdata: 32'h0,         lat: 3, exp_rdata: 32'hDEAD_BEEF};
    vecs[3] = '{is_d: 0, we: 0, addr: 32'h104, wdata: 32'h0,         lat: 1, exp_rdata: 32'h0000_0013};
    vecs[4] = '{is_d: 1, we: 0, addr: 32'h200, wdata: 32'h0,         lat: 4, exp_rdata: 32'h1234_5678};
    vecs[5] = '{is_d: 1, we: 1, addr: 32'h200, wdata: 32'hCAFE_F00D, lat: 2, exp_rdata: 32'h0};
    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Both requesters held high: fetch gets one slot after MAX_STREAK data grants.
    exp_order = "DDDDIDDDDI";
    ack_lat = 1;
    n = 0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h80; d_req = 1'b1; d_addr = 32'h84; d_we = 1'b0;
    for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (i_gnt || d_gnt) begin
        chk("order_one_hot", i_gnt & d_gnt, 0);
        got[n] = d_gnt ? "D" : "I";
        n++;
      end
    end
    chk("order_count", n, 10);
    for (int k = 0; k < n; k++) chk($sformatf("order_grant%0d", k), got[k], exp_order[k]);
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);

    // Spurious ack while idle.
    @(posedge clk); force_ack = 1;
    @(negedge clk); #1;
    chk("spur_rvalid_a", i_rvalid | d_rvalid, 0);
    @(negedge clk); #1;
    chk("spur_rvalid_b", i_rvalid | d_rvalid, 0);
    chk("spur_mem_req", mem_req, 0);
    run_vec(vecs[3], 6);

    // Reset in the middle of a data transaction, followed by a late ack.
    ack_lat = 0;
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0;
    #1; chk("rbusy_d_gnt", d_gnt, 1);
    @(negedge clk); d_req = 1'b0;
    #1; chk("rbusy_mem_req", mem_req, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rbusy_mem_req_clr", mem_req, 0);
    chk("rbusy_d_rvalid", d_rvalid, 0);
    chk("rbusy_d_rdata", d_rdata, 0);
    @(posedge clk); force_ack = 1;
    @(negedge clk); #1;
    chk("rbusy_late_ack_a", d_rvalid | i_rvalid, 0);
    @(negedge clk); #1;
    chk("rbusy_late_ack_b", d_rvalid | i_rvalid, 0);
    chk("rbusy_late_mem_req", mem_req, 0);
    run_vec(vecs[0], 7);

`ifdef ARB_TIMEOUT_EN
    run_vec(vecs[2], 8);
    ack_lat = 0;
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h400; d_we = 1'b0;
    #1; chk("tmo_d_gnt", d_gnt, 1);
    @(negedge clk); d_req = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (!mem_req) break;
      n++;
    end
    chk("tmo_busy_cycles", n, TMO);
    chk("tmo_d_rvalid", d_rvalid, 1);
    chk("tmo_d_err", d_err, 1);
    chk("tmo_d_rdata", d_rdata, 0);
    chk("tmo_i_rvalid", i_rvalid, 0);
    @(negedge clk); #1;
    chk("tmo_err_pulse", d_err | d_rvalid, 0);
    ack_lat = 1;
`endif

    // Random traffic against the transaction model.
    spur_en = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (!i_req || prev_ig) begin
        i_req  = ($urandom_range(0, 99) < 55);
        i_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      end
      if (!d_req || prev_dg) begin
        d_req   = ($urandom_range(0, 99) < 55);
        d_addr  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
      end
      #1;
      was_free = !m_busy;
      e_ig = 0; e_dg = 0;
      if (was_free) begin
        if (d_req && !(i_req && m_streak == MAXS)) e_dg = 1;
        else if (i_req) e_ig = 1;
      end
      chk("rnd_i_gnt", i_gnt, e_ig);
      chk("rnd_d_gnt", d_gnt, e_dg);
      chk("rnd_mem_req", mem_req, m_busy && !m_resp);
      if (m_busy && !m_resp) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_we", mem_we, m_we);
        if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      chk("rnd_i_rvalid", i_rvalid, m_resp && !m_owner_d);
      chk("rnd_d_rvalid", d_rvalid, m_resp && m_owner_d);
      if (m_resp) begin
        chk("rnd_rdata", m_owner_d ? d_rdata : i_rdata, m_exp);
        chk("rnd_err", i_err | d_err, 0);
      end
      if (have_i && !(m_resp && !m_owner_d)) chk("rnd_i_rdata_hold", i_rdata, last_i);
      if (have_d && !(m_resp && m_owner_d)) chk("rnd_d_rdata_hold", d_rdata, last_d);

      if (m_resp) begin
        if (m_owner_d) begin last_d = m_exp; have_d = 1; end
        else begin last_i = m_exp; have_i = 1; end
        m_busy = 0; m_resp = 0;
      end else if (m_busy && mem_ack) begin
        m_resp = 1;
      end
      if (was_free) begin
        if (e_ig || !i_req) m_streak = 0;
        else if (e_dg) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
      end
      if (e_ig || e_dg) begin
        m_busy    = 1;
        m_owner_d = e_dg;
        m_addr    = e_dg ? d_addr : i_addr;
        m_we      = e_dg && d_we;
        m_wdata   = d_wdata;
        if (m_we) begin
          ref_mem[m_addr] = m_wdata;
          m_exp = '0;
        end else begin
          m_exp = ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_val(m_addr);
        end
        ack_lat = $urandom_range(1, 4);
        n_grants++;
      end
      prev_ig = i_gnt;
      prev_dg = d_gnt;
    end
    chk("rnd_enough_grants", n_grants > 40, 1);
    i_req = 1'b0; d_req = 1'b0; spur_en = 0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
